// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: opcode/funct fields and ALU control encodings shared by the decode stage
package id_pipe_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  typedef enum logic [7:0] {
    EXE_NOP_OP  = 8'b00000000,
    EXE_SRL_OP  = 8'b00000010,
    EXE_SRA_OP  = 8'b00000011,
    EXE_ADD_OP  = 8'b00100000,
    EXE_ADDU_OP = 8'b00100001,
    EXE_AND_OP  = 8'b00100100,
    EXE_OR_OP   = 8'b00100101,
    EXE_XOR_OP  = 8'b00100110,
    EXE_NOR_OP  = 8'b00100111,
    EXE_LUI_OP  = 8'b01011100,
    EXE_SLL_OP  = 8'b01111100
  } aluop_e;
  typedef enum logic [2:0] {
    EXE_RES_NOP   = 3'b000,
    EXE_RES_LOGIC = 3'b001,
    EXE_RES_SHIFT = 3'b010,
    EXE_RES_ARITH = 3'b100
  } alusel_e;
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: operand select for one regfile read port with EX/MEM bypass and hazard detect
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_EN  = 1
) (
  input  logic               read,
  input  logic [RADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  imm,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic               ex_wreg,
  input  logic [RADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic               ex_is_load,
  input  logic               mem_wreg,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  data,
  output logic               hazard
);
  logic live, ex_hit, mem_hit;
  assign live    = read && addr != '0;
  assign ex_hit  = live && ex_wreg && ex_wd == addr;
  assign mem_hit = live && mem_wreg && mem_wd == addr;
  assign data = !read ? imm :
                addr == '0 ? '0 :
                (FWD_EN != 0 && ex_hit) ? ex_wdata :
                (FWD_EN != 0 && mem_hit) ? mem_wdata : rf_data;
  // without bypass paths any in-flight producer must drain before the read is valid
  assign hazard = FWD_EN != 0 ? ex_hit && ex_is_load : ex_hit || mem_hit;
endmodule

// File: rtl/id_pipe.sv
// id_pipe: registered decode stage for the logic/immediate subset with EX/MEM bypass,
// load-use stall request and an ID/EX output register honouring flush, stall and bubbles.
module id_pipe import id_pipe_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int FWD_EN      = 1,
  parameter int SIGN_EXT_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        inst_i,
  input  logic               inst_valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [DATA_W-1:0]  reg1_data_i,
  input  logic [DATA_W-1:0]  reg2_data_i,
  output logic               reg1_read_o,
  output logic               reg2_read_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic               ex_wreg_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wreg_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic               stall_req_o,
  output logic [7:0]         aluop_o,
  output logic [2:0]         alusel_o,
  output logic [DATA_W-1:0]  reg1_o,
  output logic [DATA_W-1:0]  reg2_o,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o,
  output logic               inst_err_o
);
  logic [5:0] op, fn;
  logic [4:0] sa;
  logic [15:0] imm;
  logic [RADDR_W-1:0] rs, rt, rd, wd_d;
  logic [DATA_W-1:0] imm1, imm2, opnd1, opnd2, zext, sext;
  logic haz1, haz2, we_d, err_d, unused_pc;
  aluop_e op_d;
  alusel_e sel_d;
  assign op   = inst_i[31:26];
  assign rs   = RADDR_W'(inst_i[25:21]);
  assign rt   = RADDR_W'(inst_i[20:16]);
  assign rd   = RADDR_W'(inst_i[15:11]);
  assign sa   = inst_i[10:6];
  assign fn   = inst_i[5:0];
  assign imm  = inst_i[15:0];
  assign zext = {{(DATA_W-16){1'b0}}, imm};
  assign sext = {{(DATA_W-16){imm[15]}}, imm};
  assign unused_pc = ^pc_i;
  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;
  // the all-zero word (SLL $0,$0,0) is the canonical NOP and is not an error
  always_comb begin
    op_d = EXE_NOP_OP;
    sel_d = EXE_RES_NOP;
    wd_d = '0;
    we_d = 1'b0;
    err_d = 1'b0;
    reg1_read_o = 1'b0;
    reg2_read_o = 1'b0;
    imm1 = '0;
    imm2 = '0;
    if (inst_valid_i && inst_i != 32'h0)
      case (op)
        OP_ORI, OP_ANDI, OP_XORI: begin
          op_d = op == OP_ORI ? EXE_OR_OP : op == OP_ANDI ? EXE_AND_OP : EXE_XOR_OP;
          sel_d = EXE_RES_LOGIC;
          wd_d = rt;
          we_d = 1'b1;
          reg1_read_o = 1'b1;
          imm2 = zext;
        end
        OP_LUI: begin
          op_d = EXE_LUI_OP;
          sel_d = EXE_RES_LOGIC;
          wd_d = rt;
          we_d = 1'b1;
          imm2 = {imm, {(DATA_W-16){1'b0}}};
        end
        OP_ADDI, OP_ADDIU: begin
          op_d = op == OP_ADDI ? EXE_ADD_OP : EXE_ADDU_OP;
          sel_d = EXE_RES_ARITH;
          wd_d = rt;
          we_d = 1'b1;
          reg1_read_o = 1'b1;
          imm2 = SIGN_EXT_EN != 0 ? sext : zext;
        end
        OP_SPECIAL:
          case (fn)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              op_d = fn == FN_AND ? EXE_AND_OP : fn == FN_OR ? EXE_OR_OP :
                     fn == FN_XOR ? EXE_XOR_OP : EXE_NOR_OP;
              sel_d = EXE_RES_LOGIC;
              wd_d = rd;
              we_d = 1'b1;
              reg1_read_o = 1'b1;
              reg2_read_o = 1'b1;
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              op_d = fn == FN_SLL ? EXE_SLL_OP : fn == FN_SRL ? EXE_SRL_OP : EXE_SRA_OP;
              sel_d = EXE_RES_SHIFT;
              wd_d = rd;
              we_d = 1'b1;
              reg2_read_o = 1'b1;
              imm1 = {{(DATA_W-5){1'b0}}, sa};
            end
            default: err_d = 1'b1;
          endcase
        default: err_d = 1'b1;
      endcase
  end
  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_EN(FWD_EN)) u_fwd1 (
    .read(reg1_read_o), .addr(rs), .imm(imm1), .rf_data(reg1_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .data(opnd1), .hazard(haz1)
  );
  id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FWD_EN(FWD_EN)) u_fwd2 (
    .read(reg2_read_o), .addr(rt), .imm(imm2), .rf_data(reg2_data_i),
    .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
    .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
    .data(opnd2), .hazard(haz2)
  );
  assign stall_req_o = haz1 | haz2;
  // flush beats stall; an unstalled hazard inserts the same bubble a flush would
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush_i || (!stall_i && stall_req_o)) begin
      aluop_o <= EXE_NOP_OP;
      alusel_o <= EXE_RES_NOP;
      reg1_o <= '0;
      reg2_o <= '0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      inst_err_o <= 1'b0;
    end else if (!stall_i) begin
      aluop_o <= op_d;
      alusel_o <= sel_d;
      reg1_o <= opnd1;
      reg2_o <= opnd2;
      wd_o <= wd_d;
      wreg_o <= we_d;
      inst_err_o <= err_d;
    end
  end
endmodule
